// File: rtl/vga_pixel_sink_if.sv
// Strobe/acknowledge byte stream from the pixel processing unit, plus the
// frame-start sync returned to it.
interface vga_pixel_sink_if;
    logic [7:0] data_i;
    logic       stb_i;
    logic       ack_i;
    logic       sync_o;

    modport master (output data_i, output stb_i, input ack_i, input sync_o);
    modport slave  (input data_i, input stb_i, output ack_i, output sync_o);
endinterface

// File: rtl/vga_pixel_sink.sv
// VGA pixel sink: buffers packed RGB bytes from the producer in a small FIFO
// and scans them out with 640x480 timing, returning a frame-start sync pulse.
// Optional build macro VGA_SINK_FLUSH_EN: flush the FIFO on every frame start.
module vga_pixel_sink #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 751,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 491,
    parameter int unsigned V_TOTAL      = 525
) (
    input  logic               clk,
    input  logic               rst,
    vga_pixel_sink_if.slave    px,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [1:0]         vga_r,
    output logic [1:0]         vga_g,
    output logic [1:0]         vga_b,
    output logic               underflow,
    output logic [FIFO_AW:0]   level
);
    localparam int unsigned SX_W  = $clog2(H_TOTAL);
    localparam int unsigned SY_W  = $clog2(V_TOTAL);
    localparam int unsigned LVL_W = FIFO_AW + 1;

    logic [SX_W-1:0]    sx_q, sx_d;
    logic [SY_W-1:0]    sy_q, sy_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ack_q, ack_d;
    logic               sync_q, sync_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [5:0]         rgb_q, rgb_d;
    logic               underflow_q, underflow_d;

    logic [5:0]         mem_q [FIFO_DEPTH];

    logic               end_x, end_y, visible, push, pop;
    logic               unused_lsb;

    // Only the RGB fields of the byte are stored.
    assign unused_lsb = ^px.data_i[1:0];

    // Next-state: scan counters, timing outputs, FIFO control and pixel fetch.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        rgb_d       = '0;

        end_x   = (sx_q == SX_W'(H_TOTAL - 1));
        end_y   = (sy_q == SY_W'(V_TOTAL - 1));
        visible = (sx_q < SX_W'(H_VISIBLE)) && (sy_q < SY_W'(V_VISIBLE));

        sx_d = end_x ? '0 : sx_q + SX_W'(1);
        if (end_x) begin
            sy_d = end_y ? '0 : sy_q + SY_W'(1);
        end

        de_d    = visible;
        hsync_d = !((sx_q >= SX_W'(H_SYNC_START)) && (sx_q <= SX_W'(H_SYNC_END)));
        vsync_d = !((sy_q >= SY_W'(V_SYNC_START)) && (sy_q <= SY_W'(V_SYNC_END)));
        sync_d  = end_x && end_y;

        // Full test uses the occupancy before any same-cycle pop.
        push  = px.stb_i && !ack_q && (level_q != LVL_W'(FIFO_DEPTH));
        pop   = visible && (level_q != '0);
        ack_d = push;

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end

        if (pop) begin
            rgb_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else if (visible) begin
            underflow_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

`ifdef VGA_SINK_FLUSH_EN
        // Frame start: drop everything buffered, including a byte taken this cycle.
        if (sync_q) begin
            rd_ptr_d = wr_ptr_d;
            level_d  = '0;
        end
`endif
    end

    // State register with asynchronous reset; syncs idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q        <= '0;
            sy_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ack_q       <= 1'b0;
            sync_q      <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ack_q       <= ack_d;
            sync_q      <= sync_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= px.data_i[7:2];
        end
    end

    assign px.ack_i  = ack_q;
    assign px.sync_o = sync_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign vga_r     = rgb_q[5:4];
    assign vga_g     = rgb_q[3:2];
    assign vga_b     = rgb_q[1:0];
    assign underflow = underflow_q;
    assign level     = level_q;
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: a full-size instance and a miniature-timing
// instance (whole frames fit in a short run), each with a queue-based model
// feeding an expected-output scoreboard.
module tb_vga_pixel_sink;
    typedef struct packed {
        logic       ack;
        logic       sync;
        logic       hs;
        logic       vs;
        logic       de;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       uf;
        logic [4:0] lvl;
    } obs_t;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int unsigned HV  = (gi == 0) ? 640 : 16;
        localparam int unsigned HSS = (gi == 0) ? 656 : 18;
        localparam int unsigned HSE = (gi == 0) ? 751 : 21;
        localparam int unsigned HT  = (gi == 0) ? 800 : 24;
        localparam int unsigned VV  = (gi == 0) ? 480 : 6;
        localparam int unsigned VSS = (gi == 0) ? 490 : 7;
        localparam int unsigned VSE = (gi == 0) ? 491 : 8;
        localparam int unsigned VT  = (gi == 0) ? 525 : 10;
        localparam int N1 = (gi == 0) ? 1000  : 300;
        localparam int N2 = (gi == 0) ? 28000 : 2400;
        localparam int N3 = (gi == 0) ? 1500  : 600;

        vga_pixel_sink_if bus ();
        logic       rst_l = 1'b0;
        logic       hs, vs, de_w, uf;
        logic [1:0] r, gg, b;
        logic [4:0] lvl;

        vga_pixel_sink #(
            .FIFO_DEPTH(16), .FIFO_AW(4),
            .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
            .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
        ) u_dut (
            .clk(clk), .rst(rst_l), .px(bus),
            .hsync(hs), .vsync(vs), .de(de_w),
            .vga_r(r), .vga_g(gg), .vga_b(b),
            .underflow(uf), .level(lvl)
        );

        // Reference model state: cycles since reset and buffered bytes.
        obs_t        expq[$];
        logic [7:0]  fifo_m[$];
        int unsigned t = 0;
        bit          m_ack = 0;
        bit          m_uf = 0;
        bit          m_sync_prev = 0;
        bit          to_flag = 0;
        bit          to_seen = 0;
        bit          done = 0;

        // Model: derive position from elapsed cycles, apply the stream rules.
        always @(posedge clk) begin : mdl
            int unsigned sx, sy;
            bit          vis, acc;
            obs_t        e;
            logic [7:0]  hb;
            if (!rst_l) begin
                sx  = t % HT;
                sy  = (t / HT) % VT;
                vis = (sx < HV) && (sy < VV);
                acc = bus.stb_i && !m_ack && (fifo_m.size() < 16);
                e      = '0;
                e.de   = vis;
                e.hs   = !((sx >= HSS) && (sx <= HSE));
                e.vs   = !((sy >= VSS) && (sy <= VSE));
                e.sync = (sx == HT - 1) && (sy == VT - 1);
                if (vis) begin
                    if (fifo_m.size() > 0) begin
                        hb  = fifo_m.pop_front();
                        e.r = hb[7:6];
                        e.g = hb[5:4];
                        e.b = hb[3:2];
                    end else begin
                        m_uf = 1'b1;
                    end
                end
                if (acc) fifo_m.push_back(bus.data_i);
`ifdef VGA_SINK_FLUSH_EN
                if (m_sync_prev) fifo_m.delete();
`endif
                m_sync_prev = e.sync;
                m_ack = acc;
                e.ack = acc;
                e.uf  = m_uf;
                e.lvl = 5'(fifo_m.size());
                expq.push_back(e);
                t++;
            end
        end

        // Monitor: compare every cycle's outputs against the scoreboard.
        always @(negedge clk) begin : mon
            obs_t got, want;
            got = {bus.ack_i, bus.sync_o, hs, vs, de_w, r, gg, b, uf, lvl};
            total++;
            if (rst_l) begin
                want    = '0;
                want.hs = 1'b1;
                want.vs = 1'b1;
                if (got !== want) begin
                    bad++;
                    $display("FAIL inst%0d reset_state got=%h want=%h at %0t", gi, got, want, $time);
                end
            end else if (expq.size() == 0) begin
                bad++;
                $display("FAIL inst%0d no_expected got=%h want=<none> at %0t", gi, got, $time);
            end else begin
                want = expq.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL inst%0d outputs got=%h want=%h at %0t", gi, got, want, $time);
                end
            end
            if (to_flag && !to_seen) begin
                to_seen = 1'b1;
                total++;
                bad++;
                $display("FAIL inst%0d fill_timeout got=no_level10 want=level10_with_ack", gi);
            end
        end

        // Stimulus: hold-strobe fill, random stream, mid-line reset, random again.
        initial begin : seq
            bit hit;
            bus.stb_i  = 1'b0;
            bus.data_i = 8'h00;
            #1 rst_l = 1'b1;
            repeat (3) @(negedge clk);
            #1;
            rst_l      = 1'b0;
            bus.stb_i  = 1'b1;
            bus.data_i = 8'hFC;
            repeat (N1) @(posedge clk);
            repeat (N2) begin
                @(posedge clk);
                #1;
                if (!bus.stb_i || bus.ack_i) begin
                    bus.stb_i  = ($urandom_range(0, 3) != 0);
                    bus.data_i = 8'($urandom);
                end
            end
            hit = 1'b0;
            for (int i = 0; i < 3000 && !hit; i++) begin
                @(posedge clk);
                #1;
                if (!bus.stb_i || bus.ack_i) begin
                    bus.stb_i  = 1'b1;
                    bus.data_i = 8'hFC;
                end
                hit = m_ack && (fifo_m.size() == 10);
            end
            if (!hit) to_flag = 1'b1;
            #2;
            rst_l       = 1'b1;
            bus.stb_i   = 1'b0;
            expq.delete();
            fifo_m.delete();
            m_ack       = 1'b0;
            m_uf        = 1'b0;
            m_sync_prev = 1'b0;
            t           = 0;
            repeat (2) @(negedge clk);
            #1 rst_l = 1'b0;
            repeat (N3) begin
                @(posedge clk);
                #1;
                if (!bus.stb_i || bus.ack_i) begin
                    bus.stb_i  = ($urandom_range(0, 2) != 0);
                    bus.data_i = 8'($urandom);
                end
            end
            @(posedge clk);
            #1 bus.stb_i = 1'b0;
            repeat (5) @(posedge clk);
            done = 1'b1;
        end
    end

    initial begin
        wait (g_inst[0].done && g_inst[1].done);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
